// File: rtl/qdec_cabac_pkg.sv
// Shared CABAC decoder definitions: context entry layout, init ROM bank
// selection, init sequencer states and the Clip3 helper.
package qdec_cabac_pkg;

    // Default context count and ctx RAM address width.
    localparam int QDEC_NUM_CTX = 192;
    localparam int QDEC_ADDR_W  = 10;

    // Init ROM bank selection (slice initType); code 3 is not a valid bank.
    typedef enum logic [1:0] {
        INIT_I = 2'd0,
        INIT_P = 2'd1,
        INIT_B = 2'd2
    } init_type_t;

    localparam logic [1:0] INIT_TYPE_ILLEGAL = 2'd3;

    // Context-initialisation sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } init_state_t;

    // One ctx RAM word: reserved bit, most-probable symbol, probability state.
    typedef struct packed {
        logic       rsvd;
        logic       mps;
        logic [5:0] pstate;
    } ctx_entry_t;

    // Clip3(lo, hi, x) on 10-bit signed values, wide enough for every
    // intermediate of the context init arithmetic.
    function automatic logic signed [9:0] clip3(
        input logic signed [9:0] lo,
        input logic signed [9:0] hi,
        input logic signed [9:0] x
    );
        logic signed [9:0] r;
        r = x;
        if (x < lo) r = lo;
        if (x > hi) r = hi;
        return r;
    endfunction

endpackage

// File: rtl/qdec_ctx_init_calc.sv
// Combinational HEVC context initialisation: initValue + SliceQpY -> ctx entry.
module qdec_ctx_init_calc
    import qdec_cabac_pkg::*;
(
    input  logic [7:0] i_init_value,
    input  logic [6:0] i_slice_qp,
    output ctx_entry_t o_entry
);

    logic signed [9:0]  w_qpc;
    logic        [6:0]  w_m;
    logic        [7:0]  w_n;
    logic signed [12:0] w_prod;
    logic signed [9:0]  w_pre;

    // Slope/offset decode, QP-scaled state, then split into (pState, valMps).
    always_comb begin
        // qpc is in 0..51, so it is always non-negative.
        w_qpc  = clip3(10'sd0, 10'sd51, 10'($signed(i_slice_qp)));
        // Modular 7/8-bit arithmetic yields the correct two's-complement m and n.
        w_m    = {3'b000, i_init_value[7:4]} * 7'd5 - 7'd45;
        w_n    = {1'b0, i_init_value[3:0], 3'b000} - 8'd16;
        w_prod = 13'($signed(w_m)) * 13'(w_qpc);
        // >>> on a signed operand is a floor shift, as the init formula needs.
        w_pre  = clip3(10'sd1, 10'sd126, 10'(w_prod >>> 4) + 10'($signed(w_n)));

        o_entry.rsvd = 1'b0;
        if (w_pre <= 10'sd63) begin
            o_entry.mps    = 1'b0;
            o_entry.pstate = 6'(10'sd63 - w_pre);
        end else begin
            o_entry.mps    = 1'b1;
            o_entry.pstate = 6'(w_pre - 10'sd64);
        end
    end

endmodule

// File: rtl/qdec_ctx_init_arb.sv
// Context-initialisation sequencer and ctx RAM port arbiter. On a slice start
// it walks every context, reads its initValue from the selected ROM bank,
// converts it and writes the ctx RAM; otherwise the ctx FSM port passes through.
//
// FSM port handshake: a request is i_fsm_en (with i_fsm_we for writes) and is
// accepted in exactly the cycle it is presented while o_fsm_gnt=1. While the
// sequencer is busy, o_fsm_gnt=0 and requests are dropped, not queued; the
// requester must hold its request until it sees o_fsm_gnt=1.
module qdec_ctx_init_arb
    import qdec_cabac_pkg::*;
#(
    parameter int NUM_CTX = QDEC_NUM_CTX,
    parameter int ADDR_W  = QDEC_ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_init_start,
    input  logic [1:0]        i_init_type,
    input  logic [6:0]        i_slice_qp,
    output logic              o_init_busy,
    output logic              o_init_done,
    output logic [ADDR_W+1:0] o_rom_addr,
    input  logic [7:0]        i_rom_data,
    input  logic [ADDR_W-1:0] i_fsm_addr,
    input  logic [7:0]        i_fsm_wdata,
    input  logic              i_fsm_we,
    input  logic              i_fsm_en,
    output logic              o_fsm_gnt,
    output logic [ADDR_W-1:0] o_ctx_addr,
    output logic [7:0]        o_ctx_wdata,
    output logic              o_ctx_we,
    output logic              o_ctx_en,
    output init_state_t       o_dbg_state
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_CTX - 1);

    init_state_t       r_state;
    init_state_t       w_next_state;
    logic              w_accept;
    logic              w_busy;

    init_type_t        r_bank;
    logic [6:0]        r_qp;
    logic [ADDR_W-1:0] r_idx;
    logic              r_drain;

    // Pipeline: stage 1 = ROM data cycle, stage 2 = RAM write cycle.
    logic              r_v1;
    logic [ADDR_W-1:0] r_a1;
    logic              r_v2;
    logic [ADDR_W-1:0] r_a2;
    ctx_entry_t        r_d2;
    ctx_entry_t        w_entry;

    // Next-state logic: start acceptance, last-index detection, drain count.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_init_start && (i_init_type != INIT_TYPE_ILLEGAL)) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (r_idx == LAST_IDX) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    // Slice parameters, context index walk and two-cycle drain counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bank  <= INIT_I;
            r_qp    <= '0;
            r_idx   <= '0;
            r_drain <= 1'b0;
        end else begin
            if (w_accept) begin
                r_bank <= init_type_t'(i_init_type);
                r_qp   <= i_slice_qp;
                r_idx  <= '0;
            end else if ((r_state == ST_RUN) && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + 1'b1;
            end
            r_drain <= (r_state == ST_DRAIN) && !r_drain;
        end
    end

    qdec_ctx_init_calc u_calc (
        .i_init_value (i_rom_data),
        .i_slice_qp   (r_qp),
        .o_entry      (w_entry)
    );

    // Address/valid pipeline; reset clears valids so an aborted walk issues no writes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1 <= 1'b0;
            r_a1 <= '0;
            r_v2 <= 1'b0;
            r_a2 <= '0;
            r_d2 <= '0;
        end else begin
            r_v1 <= (r_state == ST_RUN);
            r_a1 <= r_idx;
            r_v2 <= r_v1;
            r_a2 <= r_a1;
            r_d2 <= w_entry;
        end
    end

    // Status outputs and the ctx RAM port mux (sequencer while busy, else FSM).
    always_comb begin
        w_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        o_init_busy = w_busy;
        o_init_done = (r_state == ST_DONE);
        o_fsm_gnt   = !w_busy;
        o_rom_addr  = {r_bank, r_idx};
        o_dbg_state = r_state;
        o_ctx_addr  = i_fsm_addr;
        o_ctx_wdata = i_fsm_wdata;
        o_ctx_we    = i_fsm_we;
        o_ctx_en    = i_fsm_en;
        if (w_busy) begin
            o_ctx_addr  = r_a2;
            o_ctx_wdata = r_d2;
            o_ctx_we    = r_v2;
            o_ctx_en    = r_v2;
        end
    end

endmodule

// File: tb/tb_qdec_ctx_init_arb.sv
// Directed bench for qdec_ctx_init_arb: cycle-exact walk timing, arithmetic
// corner values, FSM port arbitration, illegal init type and reset abort.
module tb_qdec_ctx_init_arb;
    import qdec_cabac_pkg::*;

    localparam int N      = 192;
    localparam int ADDR_W = 10;

    logic              clk;
    logic              rst;
    logic              init_start;
    logic [1:0]        init_type;
    logic [6:0]        slice_qp;
    logic              init_busy;
    logic              init_done;
    logic [ADDR_W+1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [ADDR_W-1:0] fsm_addr;
    logic [7:0]        fsm_wdata;
    logic              fsm_we;
    logic              fsm_en;
    logic              fsm_gnt;
    logic [ADDR_W-1:0] ctx_addr;
    logic [7:0]        ctx_wdata;
    logic              ctx_we;
    logic              ctx_en;
    init_state_t       dbg_state;

    int checks   = 0;
    int failures = 0;

    bit         rom_const_mode;
    logic [7:0] rom_const_val;

    qdec_ctx_init_arb #(.NUM_CTX(N), .ADDR_W(ADDR_W)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_init_start (init_start),
        .i_init_type  (init_type),
        .i_slice_qp   (slice_qp),
        .o_init_busy  (init_busy),
        .o_init_done  (init_done),
        .o_rom_addr   (rom_addr),
        .i_rom_data   (rom_data),
        .i_fsm_addr   (fsm_addr),
        .i_fsm_wdata  (fsm_wdata),
        .i_fsm_we     (fsm_we),
        .i_fsm_en     (fsm_en),
        .o_fsm_gnt    (fsm_gnt),
        .o_ctx_addr   (ctx_addr),
        .o_ctx_wdata  (ctx_wdata),
        .o_ctx_we     (ctx_we),
        .o_ctx_en     (ctx_en),
        .o_dbg_state  (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Init ROM content: one constant value, or an address-dependent pattern.
    function automatic logic [7:0] rom_val(input logic [11:0] a);
        if (rom_const_mode) return rom_const_val;
        return 8'(int'(a[9:0]) * 37 + int'(a[11:10]) * 11);
    endfunction

    // ROM with one cycle of read latency.
    always @(posedge clk) rom_data <= rom_val(rom_addr);

    // Reference context init in plain integer arithmetic.
    function automatic logic [7:0] ref_entry(input int iv, input int qp);
        int qpc, m, n, pre;
        qpc = (qp < 0) ? 0 : ((qp > 51) ? 51 : qp);
        m   = (iv / 16) * 5 - 45;
        n   = (iv % 16) * 8 - 16;
        pre = ((m * qpc) >>> 4) + n;
        if (pre < 1)   pre = 1;
        if (pre > 126) pre = 126;
        if (pre <= 63) return 8'(63 - pre);
        return 8'(8'h40 | (pre - 64));
    endfunction

    task automatic test_reset();
        rst        = 1'b1;
        init_start = 1'b0;
        init_type  = 2'd0;
        slice_qp   = 7'd0;
        fsm_addr   = 10'd5;
        fsm_wdata  = 8'h12;
        fsm_we     = 1'b1;
        fsm_en     = 1'b1;
        rom_const_mode = 1'b1;
        rom_const_val  = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (init_busy !== 1'b0) begin failures++; $display("FAIL reset_busy act=%0b exp=0", init_busy); end
        checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_done act=%0b exp=0", init_done); end
        checks++; if (rom_addr !== 12'd0) begin failures++; $display("FAIL reset_rom_addr act=%0h exp=0", rom_addr); end
        checks++; if (fsm_gnt !== 1'b1) begin failures++; $display("FAIL reset_gnt act=%0b exp=1", fsm_gnt); end
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state act=%0d exp=0", dbg_state); end
        checks++;
        if (ctx_we !== 1'b1 || ctx_en !== 1'b1 || ctx_addr !== 10'd5 || ctx_wdata !== 8'h12) begin
            failures++;
            $display("FAIL reset_passthru act=we%0b en%0b a%0d d%0h exp=we1 en1 a5 d12", ctx_we, ctx_en, ctx_addr, ctx_wdata);
        end
        rst    = 1'b0;
        fsm_we = 1'b0;
        fsm_en = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // One full init walk started at cycle 0; checks every cycle up to return to IDLE.
    // With use_const the ROM returns const_iv and every entry must equal exp_const.
    task automatic run_sequence(input string name, input logic [1:0] typ, input int qp,
                                input bit use_const, input logic [7:0] const_iv,
                                input logic [7:0] exp_const, input bit second_start);
        logic        exp_busy;
        logic [11:0] exp_ra;
        logic [7:0]  exp_d;
        rom_const_mode = use_const;
        rom_const_val  = const_iv;
        // Cycle 0: start plus a simultaneous FSM write, which is still granted.
        @(negedge clk);
        init_start = 1'b1;
        init_type  = typ;
        slice_qp   = 7'(qp);
        fsm_en     = 1'b1;
        fsm_we     = 1'b1;
        fsm_addr   = 10'd9;
        fsm_wdata  = 8'hAA;
        #1;
        checks++;
        if (fsm_gnt !== 1'b1 || ctx_we !== 1'b1 || ctx_addr !== 10'd9 || ctx_wdata !== 8'hAA) begin
            failures++;
            $display("FAIL %s start_cycle_gnt act=g%0b we%0b a%0d d%0h exp=g1 we1 a9 dAA", name, fsm_gnt, ctx_we, ctx_addr, ctx_wdata);
        end
        for (int c = 1; c <= N + 4; c++) begin
            @(negedge clk);
            exp_busy = (c >= 1) && (c <= N + 2);
            checks++;
            if (init_busy !== exp_busy) begin failures++; $display("FAIL %s busy c=%0d act=%0b exp=%0b", name, c, init_busy, exp_busy); end
            checks++;
            if (fsm_gnt !== !exp_busy) begin failures++; $display("FAIL %s gnt c=%0d act=%0b exp=%0b", name, c, fsm_gnt, !exp_busy); end
            checks++;
            if (init_done !== (c == N + 3)) begin failures++; $display("FAIL %s done c=%0d act=%0b exp=%0b", name, c, init_done, (c == N + 3)); end
            if (c <= N) begin
                exp_ra = {typ, 10'(c - 1)};
                checks++;
                if (rom_addr !== exp_ra) begin failures++; $display("FAIL %s rom_addr c=%0d act=%0h exp=%0h", name, c, rom_addr, exp_ra); end
            end
            if (c >= 3 && c <= N + 2) begin
                exp_d = use_const ? exp_const : ref_entry(int'(rom_val({typ, 10'(c - 3)})), qp);
                checks++;
                if (ctx_we !== 1'b1 || ctx_en !== 1'b1 || ctx_addr !== 10'(c - 3) || ctx_wdata !== exp_d) begin
                    failures++;
                    $display("FAIL %s write c=%0d act=we%0b en%0b a%0d d%0h exp=we1 en1 a%0d d%0h",
                             name, c, ctx_we, ctx_en, ctx_addr, ctx_wdata, c - 3, exp_d);
                end
            end else if (exp_busy) begin
                checks++;
                if (ctx_en !== 1'b0 || ctx_we !== 1'b0) begin failures++; $display("FAIL %s fsm_dropped c=%0d act=en%0b we%0b exp=en0 we0", name, c, ctx_en, ctx_we); end
            end else begin
                checks++;
                if (ctx_we !== 1'b1 || ctx_addr !== 10'd9) begin failures++; $display("FAIL %s fsm_after c=%0d act=we%0b a%0d exp=we1 a9", name, c, ctx_we, ctx_addr); end
            end
            init_start = (second_start && c == 50) ? 1'b1 : 1'b0;
            if (second_start && c == 50) init_type = typ ^ 2'd1;
        end
        fsm_en = 1'b0;
        fsm_we = 1'b0;
    endtask

    task automatic test_illegal_type();
        @(negedge clk);
        init_start = 1'b1;
        init_type  = 2'd3;
        slice_qp   = 7'd26;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            init_start = 1'b0;
            checks++;
            if (init_busy !== 1'b0 || init_done !== 1'b0 || dbg_state !== ST_IDLE) begin
                failures++;
                $display("FAIL illegal_type c=%0d act=busy%0b done%0b st%0d exp=busy0 done0 st0", c, init_busy, init_done, dbg_state);
            end
        end
    endtask

    task automatic test_fsm_after_done();
        @(negedge clk);
        fsm_en    = 1'b1;
        fsm_we    = 1'b1;
        fsm_addr  = 10'd7;
        fsm_wdata = 8'h55;
        #1;
        checks++;
        if (fsm_gnt !== 1'b1 || ctx_we !== 1'b1 || ctx_en !== 1'b1 || ctx_addr !== 10'd7 || ctx_wdata !== 8'h55) begin
            failures++;
            $display("FAIL fsm_write act=g%0b we%0b en%0b a%0d d%0h exp=g1 we1 en1 a7 d55", fsm_gnt, ctx_we, ctx_en, ctx_addr, ctx_wdata);
        end
        @(negedge clk);
        fsm_we   = 1'b0;
        fsm_addr = 10'd3;
        #1;
        checks++;
        if (ctx_we !== 1'b0 || ctx_en !== 1'b1 || ctx_addr !== 10'd3) begin
            failures++;
            $display("FAIL fsm_read act=we%0b en%0b a%0d exp=we0 en1 a3", ctx_we, ctx_en, ctx_addr);
        end
        @(negedge clk);
        fsm_en = 1'b0;
    endtask

    task automatic test_reset_abort();
        rom_const_mode = 1'b1;
        rom_const_val  = 8'd154;
        @(negedge clk);
        init_start = 1'b1;
        init_type  = 2'd0;
        slice_qp   = 7'd26;
        for (int c = 1; c <= N + 10; c++) begin
            @(negedge clk);
            init_start = 1'b0;
            if (c == 100) begin
                checks++;
                if (init_busy !== 1'b1 || ctx_we !== 1'b1 || ctx_addr !== 10'd97) begin
                    failures++;
                    $display("FAIL abort_pre act=busy%0b we%0b a%0d exp=busy1 we1 a97", init_busy, ctx_we, ctx_addr);
                end
            end
            if (c > 100) begin
                checks++;
                if (ctx_we !== 1'b0 || init_busy !== 1'b0 || init_done !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_post c=%0d act=we%0b busy%0b done%0b exp=we0 busy0 done0", c, ctx_we, init_busy, init_done);
                end
            end
            rst = (c == 100) ? 1'b1 : 1'b0;
        end
    endtask

    initial begin
        test_reset();
        run_sequence("iv154_qp26", 2'd0, 26, 1'b1, 8'd154, 8'h40, 1'b1);
        test_fsm_after_done();
        run_sequence("iv139_qp26", 2'd1, 26, 1'b1, 8'd139, 8'h00, 1'b0);
        run_sequence("iv0_qp51", 2'd2, 51, 1'b1, 8'd0, 8'h3E, 1'b0);
        run_sequence("iv255_qp51", 2'd0, 51, 1'b1, 8'd255, 8'h7E, 1'b0);
        run_sequence("iv0_qpneg5", 2'd1, -5, 1'b1, 8'd0, 8'h3E, 1'b0);
        run_sequence("varied_qp30", 2'd2, 30, 1'b0, 8'd0, 8'h00, 1'b1);
        run_sequence("varied_qp45", 2'd1, 45, 1'b0, 8'd0, 8'h00, 1'b0);
        test_illegal_type();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
